// File: rtl/day_of_month_calc.sv
// Days-in-month limit for the date counter, from BCD month and year digits.
// Gregorian leap rule; all outputs registered with one cycle of latency.
module day_of_month_calc #(
  parameter logic [4:0] RESET_DAYS = 5'd31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] month_unit,
  input  logic [3:0] month_ten,
  input  logic [3:0] year_unit,
  input  logic [3:0] year_ten,
  input  logic [3:0] year_hundered,
  input  logic [3:0] year_thousand,
  output logic [4:0] max_days,
  output logic       leap_year,
  output logic       month_valid
);

  logic [4:0] max_days_q, max_days_d;
  logic       leap_q, leap_d;
  logic       valid_q, valid_d;

  logic       century;
  logic [3:0] lo_digit;
  logic       hi_odd;
  logic [1:0] mod4;

  // 10*hi + lo mod 4 reduces to (2*(hi mod 2) + lo) mod 4, so only two
  // bits of the low digit and the parity of the high digit matter.
  always_comb begin
    century  = (year_ten == 4'd0) && (year_unit == 4'd0);
    lo_digit = century ? year_hundered : year_unit;
    hi_odd   = century ? year_thousand[0] : year_ten[0];
    mod4     = {hi_odd, 1'b0} + lo_digit[1:0];
    leap_d   = (mod4 == 2'd0);
  end

  always_comb begin
    valid_d    = 1'b0;
    max_days_d = 5'd31;
    if (month_ten == 4'd0) begin
      valid_d = (month_unit >= 4'd1) && (month_unit <= 4'd9);
      if (valid_d) begin
        case (month_unit)
          4'd2:                    max_days_d = leap_d ? 5'd29 : 5'd28;
          4'd4, 4'd6, 4'd9:        max_days_d = 5'd30;
          default:                 max_days_d = 5'd31;
        endcase
      end
    end else if (month_ten == 4'd1) begin
      valid_d = (month_unit <= 4'd2);
      if (month_unit == 4'd1) max_days_d = 5'd30;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_days_q <= RESET_DAYS;
      leap_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      max_days_q <= max_days_d;
      leap_q     <= leap_d;
      valid_q    <= valid_d;
    end
  end

  assign max_days    = max_days_q;
  assign leap_year   = leap_q;
  assign month_valid = valid_q;

endmodule

// File: tb/tb_day_of_month_calc.sv
// Directed-vector bench for day_of_month_calc: table sweep plus reset and
// latency sequences.
module tb_day_of_month_calc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] month_unit, month_ten, year_unit, year_ten, year_hundered, year_thousand;
  logic [4:0] max_days;
  logic       leap_year, month_valid;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  day_of_month_calc dut (
    .clk           (clk),
    .rst           (rst),
    .month_unit    (month_unit),
    .month_ten     (month_ten),
    .year_unit     (year_unit),
    .year_ten      (year_ten),
    .year_hundered (year_hundered),
    .year_thousand (year_thousand),
    .max_days      (max_days),
    .leap_year     (leap_year),
    .month_valid   (month_valid)
  );

  typedef struct {
    string      name;
    logic [3:0] mt, mu, yth, yh, yt, yu;
    int         days;
    int         leap;
    int         valid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] mt, mu, yth, yh, yt, yu);
    month_ten = mt; month_unit = mu;
    year_thousand = yth; year_hundered = yh; year_ten = yt; year_unit = yu;
  endtask

  task automatic check_all(input string name, input int d, input int l, input int v);
    chk({name, " days"},  int'(max_days),    d);
    chk({name, " leap"},  int'(leap_year),   l);
    chk({name, " valid"}, int'(month_valid), v);
  endtask

  initial begin
    vecs.push_back('{"feb2005", 4'd0, 4'd2, 4'd2, 4'd0, 4'd0, 4'd5, 28, 0, 1});
    vecs.push_back('{"feb2800", 4'd0, 4'd2, 4'd2, 4'd8, 4'd0, 4'd0, 29, 1, 1});
    vecs.push_back('{"feb2104", 4'd0, 4'd2, 4'd2, 4'd1, 4'd0, 4'd4, 29, 1, 1});
    vecs.push_back('{"feb2100", 4'd0, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0, 28, 0, 1});
    vecs.push_back('{"feb1900", 4'd0, 4'd2, 4'd1, 4'd9, 4'd0, 4'd0, 28, 0, 1});
    vecs.push_back('{"feb0000", 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 29, 1, 1});
    vecs.push_back('{"jan2736", 4'd0, 4'd1, 4'd2, 4'd7, 4'd3, 4'd6, 31, 1, 1});
    vecs.push_back('{"dec3401", 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 31, 0, 1});
    vecs.push_back('{"nov5225", 4'd1, 4'd1, 4'd5, 4'd2, 4'd2, 4'd5, 30, 0, 1});
    vecs.push_back('{"jul2000", 4'd0, 4'd7, 4'd2, 4'd0, 4'd0, 4'd0, 31, 1, 1});
    vecs.push_back('{"apr2023", 4'd0, 4'd4, 4'd2, 4'd0, 4'd2, 4'd3, 30, 0, 1});
    vecs.push_back('{"sep1996", 4'd0, 4'd9, 4'd1, 4'd9, 4'd9, 4'd6, 30, 1, 1});
    vecs.push_back('{"jun2012", 4'd0, 4'd6, 4'd2, 4'd0, 4'd1, 4'd2, 30, 1, 1});
    vecs.push_back('{"oct2001", 4'd1, 4'd0, 4'd2, 4'd0, 4'd0, 4'd1, 31, 0, 1});
    vecs.push_back('{"m00y2024", 4'd0, 4'd0, 4'd2, 4'd0, 4'd2, 4'd4, 31, 1, 0});
    vecs.push_back('{"m13y2024", 4'd1, 4'd3, 4'd2, 4'd0, 4'd2, 4'd4, 31, 1, 0});
    vecs.push_back('{"m0A2023", 4'd0, 4'hA, 4'd2, 4'd0, 4'd2, 4'd3, 31, 0, 0});
    vecs.push_back('{"m21y2023", 4'd2, 4'd1, 4'd2, 4'd0, 4'd2, 4'd3, 31, 0, 0});
    // year tens 1, units 0xC: 10+12 = 22, not a multiple of 4
    vecs.push_back('{"feb_nbcd", 4'd0, 4'd2, 4'd2, 4'd0, 4'd1, 4'hC, 28, 0, 1});

    rst = 1'b1;
    drive(4'd1, 4'd1, 4'd2, 4'd0, 4'd2, 4'd4);
    #1;
    check_all("reset", 31, 0, 0);

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].mt, vecs[i].mu, vecs[i].yth, vecs[i].yh, vecs[i].yt, vecs[i].yu);
      @(posedge clk);
      #1;
      check_all(vecs[i].name, vecs[i].days, vecs[i].leap, vecs[i].valid);
    end

    // Latency: a mid-cycle input change must not show until the next edge.
    @(negedge clk);
    drive(4'd0, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    chk("lat feb2100", int'(max_days), 28);
    #2;
    drive(4'd0, 4'd2, 4'd2, 4'd1, 4'd0, 4'd4);
    #1;
    chk("lat hold", int'(max_days), 28);
    chk("lat hold leap", int'(leap_year), 0);
    @(posedge clk);
    #1;
    chk("lat feb2104", int'(max_days), 29);
    chk("lat feb2104 leap", int'(leap_year), 1);

    // Reset pulse between edges while showing 30.
    @(negedge clk);
    drive(4'd1, 4'd1, 4'd2, 4'd0, 4'd2, 4'd3);
    @(posedge clk);
    #1;
    chk("pre-rst nov", int'(max_days), 30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("mid rst", 31, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("post-rst hold", int'(max_days), 31);
    @(posedge clk);
    #1;
    check_all("post-rst nov", 30, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
